// File: rtl/spart_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : spart_rx_if
// Description : Bus-side bundle for the SPART receiver (baud tick, line, byte).
// Revision    : 1.0
// ============================================================================
interface spart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx_baud_en;
    logic                 rxd;
    logic                 rd_ack;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rda;
    logic                 framing_err;
    logic                 overrun;

    modport master (
        output rx_baud_en, rxd, rd_ack,
        input  rx_data, rda, framing_err, overrun
    );

    modport slave (
        input  rx_baud_en, rxd, rd_ack,
        output rx_data, rda, framing_err, overrun
    );
endinterface
`default_nettype wire

// File: rtl/spart_rx.sv
`default_nettype none
// ============================================================================
// Module      : spart_rx
// Description : 8N1 UART receiver with 16x oversampling and a one-byte holding
//               register carrying data-available, framing and overrun flags.
// Revision    : 1.0
// ============================================================================
module spart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    spart_rx_if.slave   bus
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] c_TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] c_TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] c_BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [TW-1:0]        r_tick,  w_tick_nxt;
    logic [BW-1:0]        r_bit,   w_bit_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic                 w_done;

    logic [1:0]           r_sync;
    logic                 w_line;

    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rda;
    logic                 r_framing_err;
    logic                 r_overrun;

    assign w_line = r_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], bus.rxd};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_tick  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tick  <= w_tick_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // Everything below only moves on baud ticks; between ticks the state holds.
    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_done      = 1'b0;
        if (bus.rx_baud_en) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_line) begin
                        w_state_nxt = S_START;
                        w_tick_nxt  = '0;
                    end
                end
                S_START: begin
                    if (r_tick == c_TICK_MID) begin
                        w_tick_nxt = '0;
                        if (!w_line) begin
                            w_state_nxt = S_DATA;
                            w_bit_nxt   = '0;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_tick_nxt = r_tick + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_tick == c_TICK_LAST) begin
                        w_tick_nxt  = '0;
                        w_shift_nxt = {w_line, r_shift[DATA_BITS-1:1]};
                        w_bit_nxt   = r_bit + 1'b1;
                        if (r_bit == c_BIT_LAST) begin
                            w_state_nxt = S_STOP;
                        end
                    end else begin
                        w_tick_nxt = r_tick + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_tick == c_TICK_LAST) begin
                        w_tick_nxt  = '0;
                        w_state_nxt = S_IDLE;
                        w_done      = 1'b1;
                    end else begin
                        w_tick_nxt = r_tick + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_tick_nxt  = '0;
                end
            endcase
        end
    end

    // An acknowledge in the completion cycle frees the holding register in time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_data     <= '0;
            r_rda         <= 1'b0;
            r_framing_err <= 1'b0;
            r_overrun     <= 1'b0;
        end else if (w_done) begin
            if (!r_rda || bus.rd_ack) begin
                r_rx_data     <= r_shift;
                r_rda         <= 1'b1;
                r_framing_err <= ~w_line;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (bus.rd_ack) begin
            r_rda         <= 1'b0;
            r_framing_err <= 1'b0;
            r_overrun     <= 1'b0;
        end
    end

    assign bus.rx_data     = r_rx_data;
    assign bus.rda         = r_rda;
    assign bus.framing_err = r_framing_err;
    assign bus.overrun     = r_overrun;

endmodule
`default_nettype wire
